// File: rtl/display_mem_arbiter.sv
// Two-port arbiter for the shared display/sprite BRAM: port 0 has priority and port 1 is aged (round-robin under DISPLAY_MEM_ARB_RR_EN).
// Grant is combinational, the issue is registered at t+1, and read data returns at t+1+RD_LAT. busy1 flags a refused port-1 request.
module display_mem_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy1
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we;
  } acc_t;

  acc_t          acc0, acc1;
  logic [7:0]    wait_cnt;
  logic [RD_LAT:0] tag_v;
  logic [RD_LAT:0] tag_p;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rd_issue;

  assign acc0 = '{addr: addr0, din: wdata0, we: we0};
  assign acc1 = '{addr: addr1, din: wdata1, we: we1};

`ifdef DISPLAY_MEM_ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b0;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    wait_cnt <= '0;
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst || !req1 || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt1 = (wait_cnt == MAX_WAIT_C);
        gnt0 = ~gnt1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end
`endif

  assign busy1    = req1 & ~gnt1 & ~rst;
  assign rd_issue = (gnt0 & ~we0) | (gnt1 & ~we1);

  // Tag stage k is valid during issue+k, so the last stage lines up with BRAM data.
  assign rvalid0 = ~rst & tag_v[RD_LAT] & ~tag_p[RD_LAT];
  assign rvalid1 = ~rst & tag_v[RD_LAT] &  tag_p[RD_LAT];
  assign rdata0  = rvalid0 ? mem_dout : rdata0_q;
  assign rdata1  = rvalid1 ? mem_dout : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      tag_v    <= '0;
      tag_p    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (gnt0) begin
        mem_addr <= acc0.addr;
        mem_din  <= acc0.din;
        mem_we   <= acc0.we;
      end else if (gnt1) begin
        mem_addr <= acc1.addr;
        mem_din  <= acc1.din;
        mem_we   <= acc1.we;
      end else begin
        mem_we   <= 1'b0;
      end
      tag_v <= {tag_v[RD_LAT-1:0], rd_issue};
      tag_p <= {tag_p[RD_LAT-1:0], gnt1};
      if (rvalid0) rdata0_q <= mem_dout;
      if (rvalid1) rdata1_q <= mem_dout;
    end
  end

endmodule

// File: tb/tb_display_mem_arbiter.sv
// Directed bench for display_mem_arbiter with a write-first, 2-cycle-latency BRAM model.
module tb_display_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, gnt0, rvalid0;
  logic [14:0] addr0;
  logic [7:0]  wdata0, rdata0;
  logic        req1, we1, gnt1, rvalid1;
  logic [14:0] addr1;
  logic [7:0]  wdata1, rdata1;
  logic [14:0] mem_addr;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_we, busy1;

  logic [7:0]  mem [0:32767];
  logic [7:0]  rd1 = '0;
  logic [7:0]  rd2 = '0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  display_mem_arbiter #(.AW(15), .DW(8), .RD_LAT(2), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy1(busy1)
  );

  // Write-first BRAM: data for an access issued in cycle c appears on mem_dout in c+2.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    rd1 <= mem_we ? mem_din : mem[mem_addr];
    rd2 <= rd1;
  end
  assign mem_dout = rd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem[15'h0100] <= 8'h5A;
    mem[15'h0200] <= 8'hA1;
    mem[15'h0201] <= 8'hB2;
    mem[15'h0300] <= 8'hC3;
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset state, with both requests raised: reset wins
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rdata1", 32'(rdata1), 0);
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    // Port 0 single read of 0x0100
    req0 = 1'b1; addr0 = 15'h0100; we0 = 1'b0;
    @(negedge clk);
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_gnt1", 32'(gnt1), 0);
    tick(); req0 = 1'b0;
    @(negedge clk);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0100);
    chk("t1_mem_we", 32'(mem_we), 0);
    tick(); @(negedge clk);
    chk("t1_rvalid0_early", 32'(rvalid0), 0);
    tick(); @(negedge clk);
    chk("t1_rvalid0", 32'(rvalid0), 1);
    chk("t1_rdata0", 32'(rdata0), 32'h5A);
    chk("t1_rvalid1", 32'(rvalid1), 0);
    tick(); @(negedge clk);
    chk("t1_rvalid0_drop", 32'(rvalid0), 0);
    chk("t1_rdata0_hold", 32'(rdata0), 32'h5A);

    // Both ports held: 8 grants to port 0, then one to port 1
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 15'h1000; wdata0 = 8'h00;
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h1001; wdata1 = 8'h00;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk($sformatf("age_gnt0_%0d", i), 32'(gnt0), ((i % 9) != 8) ? 32'd1 : 32'd0);
      chk($sformatf("age_gnt1_%0d", i), 32'(gnt1), ((i % 9) == 8) ? 32'd1 : 32'd0);
      chk($sformatf("age_busy1_%0d", i), 32'(busy1), ((i % 9) != 8) ? 32'd1 : 32'd0);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Read-after-write: port 1 writes 0x33 to 0x3300, port 0 reads it next cycle
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h3300; wdata1 = 8'h33;
    @(negedge clk);
    chk("raw_gnt1", 32'(gnt1), 1);
    chk("raw_gnt0_idle", 32'(gnt0), 0);
    tick();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 15'h3300;
    @(negedge clk);
    chk("raw_gnt0", 32'(gnt0), 1);
    chk("raw_mem_we", 32'(mem_we), 1);
    chk("raw_mem_addr", 32'(mem_addr), 32'h3300);
    chk("raw_mem_din", 32'(mem_din), 32'h33);
    tick(); req0 = 1'b0;
    @(negedge clk);
    chk("raw_mem_we_rd", 32'(mem_we), 0);
    tick(); @(negedge clk);
    chk("raw_rvalid0_early", 32'(rvalid0), 0);
    tick(); @(negedge clk);
    chk("raw_rvalid0", 32'(rvalid0), 1);
    chk("raw_rdata0", 32'(rdata0), 32'h33);

    // Interleaved pipelined reads A, B (port 0) and C (port 1)
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0200;
    @(negedge clk); chk("il_gnt_a", 32'(gnt0), 1);
    tick(); addr0 = 15'h0201;
    @(negedge clk); chk("il_gnt_b", 32'(gnt0), 1);
    tick(); req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0300;
    @(negedge clk);
    chk("il_gnt_c", 32'(gnt1), 1);
    chk("il_busy1", 32'(busy1), 0);
    tick(); req1 = 1'b0;
    @(negedge clk);
    chk("il_rvalid0_a", 32'(rvalid0), 1);
    chk("il_rdata0_a", 32'(rdata0), 32'hA1);
    chk("il_rvalid1_a", 32'(rvalid1), 0);
    tick(); @(negedge clk);
    chk("il_rvalid0_b", 32'(rvalid0), 1);
    chk("il_rdata0_b", 32'(rdata0), 32'hB2);
    tick(); @(negedge clk);
    chk("il_rvalid1_c", 32'(rvalid1), 1);
    chk("il_rdata1_c", 32'(rdata1), 32'hC3);
    chk("il_rvalid0_c", 32'(rvalid0), 0);

    // Reset one cycle after a port 1 read grant
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0300;
    @(negedge clk); chk("rr_gnt1", 32'(gnt1), 1);
    tick(); req1 = 1'b0; req0 = 1'b1; rst = 1'b1;
    @(negedge clk); chk("rr_gnt0_in_rst", 32'(gnt0), 0);
    tick(); rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("rr_mem_addr", 32'(mem_addr), 0);
    chk("rr_mem_din", 32'(mem_din), 0);
    chk("rr_mem_we", 32'(mem_we), 0);
    chk("rr_rvalid1", 32'(rvalid1), 0);
    chk("rr_rdata1", 32'(rdata1), 0);
    chk("rr_rdata0", 32'(rdata0), 0);
    chk("rr_busy1", 32'(busy1), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk($sformatf("rr_no_rvalid1_%0d", i), 32'(rvalid1), 0);
    end

    // Port 1 alone: 20 back-to-back writes
    tick();
    for (int i = 0; i < 20; i++) begin
      req1 = 1'b1; we1 = 1'b1; addr1 = 15'(32'h2000 + i); wdata1 = 8'(i);
      @(negedge clk);
      chk($sformatf("bulk_gnt1_%0d", i), 32'(gnt1), 1);
      chk($sformatf("bulk_busy1_%0d", i), 32'(busy1), 0);
      if (i > 0) begin
        chk($sformatf("bulk_mem_we_%0d", i), 32'(mem_we), 1);
        chk($sformatf("bulk_mem_addr_%0d", i), 32'(mem_addr), 32'h2000 + i - 1);
      end
      tick();
    end
    req1 = 1'b0;
    @(negedge clk);
    chk("bulk_last_we", 32'(mem_we), 1);
    chk("bulk_last_addr", 32'(mem_addr), 32'h2013);
    chk("bulk_last_din", 32'(mem_din), 32'h13);
    tick(); @(negedge clk);
    chk("bulk_we_off", 32'(mem_we), 0);

    // Read back one loaded byte through port 1
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 15'h2005;
    @(negedge clk); chk("rb_gnt1", 32'(gnt1), 1);
    tick(); req1 = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rb_rvalid1", 32'(rvalid1), 1);
    chk("rb_rdata1", 32'(rdata1), 32'h05);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_mem_arbiter.md
Name: display_mem_arbiter

Overview:
- Shares the single-port display/sprite BRAM between two requesters:
  - Port 0: pixel updater (frame-buffer writes, sprite reads). High priority.
  - Port 1: UART sprite/ground loader (bulk writes, readback). Low priority, aged.
- Issues at most one access per clock and returns read data tagged to the requester that issued it.
- Sits between the requesters and the BRAM.

Parameters:
- AW, 15, memory address width (covers 12800 screen + sprite area)
- DW, 8, memory data width
- RD_LAT, 2, BRAM read latency in cycles, counted from the issue cycle (min 1, max 4)
- MAX_WAIT, 8, cycles port 1 may be refused before it overrides port 0 (min 1, max 255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req0  in  1  port 0 request; held until gnt0
- addr0  in  AW  port 0 address
- wdata0  in  DW  port 0 write data
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- gnt0  out  1  port 0 grant pulse (combinational, same cycle as the decision)
- rvalid0  out  1  port 0 read data valid, 1-cycle pulse
- rdata0  out  DW  port 0 read data
- req1, addr1, wdata1, we1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- mem_addr  out  AW  BRAM address (registered)
- mem_din  out  DW  BRAM write data (registered)
- mem_we  out  1  BRAM write enable (registered)
- mem_dout  in  DW  BRAM read data
- busy1  out  1  port 1 pending and not granted this cycle (for loader flow control)

Behaviour:
- Reset: all outputs 0, wait counter 0, read-tag pipeline cleared, round-robin pointer = port 0. Any read in flight when rst asserts is discarded; no rvalid follows the reset.
- Arbitration (combinational, cycle t):
  - Only req0: gnt0.
  - Only req1: gnt1.
  - Both requesting: gnt1 if wait_cnt == MAX_WAIT, else gnt0.
  - At most one grant per cycle. No grant without req.
- Issue (cycle t+1):
  - mem_addr, mem_din and mem_we take the granted port's fields.
  - With no grant, mem_we = 0 and mem_addr/mem_din hold their last values.
- Read return: for a granted read, a tag {valid, port} enters an RD_LAT-deep shift register. At t+1+RD_LAT, the tagged port's rvalid pulses and its rdata = mem_dout of that cycle.
  - rdataN holds its value between pulses.
  - Writes produce no rvalid.
  - Back-to-back reads from either port are fully pipelined: one grant per cycle, in-order return.
- Requester protocol:
  - After gnt a requester may change fields or drop req the same cycle (fields are sampled at the grant).
  - A requester may re-request on the very next cycle.
  - Dropping req before gnt withdraws the request; wait_cnt clears.
- wait_cnt (8 bits):
  - Increments, saturating at MAX_WAIT, each cycle req1 = 1 and gnt1 = 0.
  - Clears on gnt1 or req1 = 0.
- busy1 = req1 & ~gnt1.
- Read-after-write: a read of an address issued the cycle after a write to that address returns the new data; write-first BRAM mode is required.
- Simultaneous reset and request: reset wins; no grant that cycle.

Optional Feature:
- Macro: DISPLAY_MEM_ARB_RR_EN.
- Defined: the priority-with-aging rule is replaced by round-robin.
  - On a conflict, the port not granted last wins.
  - The pointer updates on every grant.
  - wait_cnt is unused; it is held at 0.
- Undefined: fixed priority to port 0 with MAX_WAIT aging, as above.

Test Plan:
- Port 0 read only, addr0=0x0100, BRAM preloaded 0x5A, RD_LAT=2 -> gnt0 at t, mem_addr=0x0100 at t+1, rvalid0=1 with rdata0=0x5A at t+3, rvalid1 stays 0.
- req0 and req1 held high continuously, MAX_WAIT=8 -> pattern of 8 gnt0 then 1 gnt1, repeating; wait_cnt returns to 0 after each gnt1. With DISPLAY_MEM_ARB_RR_EN -> gnt0 and gnt1 strictly alternate.
- Port 1 writes 0x33 to 0x3300 at t, port 0 reads 0x3300 at t+1 -> rdata0=0x33 at t+1+1+RD_LAT.
- Interleaved reads: port 0 reads A, B, port 1 reads C on consecutive grants -> rvalid0, rvalid0, rvalid1 on three consecutive cycles with the matching data.
- rst asserted one cycle after a port 1 read grant -> no rvalid1 ever appears; all outputs 0 on the following cycle.
- req1 alone for 20 cycles of writes -> gnt1 every cycle, busy1=0, mem_we=1 on cycles 2..21.
